// File: rtl/mem_arbiter.sv
// Two-requester (CPU/DMA) round-robin arbiter in front of a single-port synchronous RAM.
// Latency: gnt 1 cycle after the sampling edge, write committed 1 cycle later, rvalid 3 cycles after sampling.
// Backpressure: requests are sampled only in IDLE; a requester holds its request until it sees its gnt.
module mem_arbiter #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  output logic              cpu_gnt,
  output logic              dma_gnt,
  output logic              cpu_rvalid,
  output logic              dma_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic [DATA_W-1:0] dma_rdata,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_data,
  output logic              mem_rden,
  output logic              mem_wren,
  input  logic [DATA_W-1:0] mem_q,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, ACCESS, RDWAIT} state_t;

  state_t              state_q;
  logic                last_dma_q;   // 1 = DMA was granted last (reset value, so CPU wins the first tie)
  logic                owner_dma_q;  // requester that owns the access in flight
  logic                cpu_gnt_q, dma_gnt_q;
  logic                cpu_rvalid_q, dma_rvalid_q;
  logic [DATA_W-1:0]   cpu_rdata_q, dma_rdata_q;
  logic [ADDR_W-1:0]   mem_address_q;
  logic [DATA_W-1:0]   mem_data_q;
  logic                mem_rden_q, mem_wren_q;
  logic                busy_q;

  logic                pick_dma_d;
  logic                sel_we_d;
  logic [ADDR_W-1:0]   sel_addr_d;
  logic [DATA_W-1:0]   sel_wdata_d;

  // Round-robin winner: DMA wins if it is alone, or on a tie when the CPU was granted last.
  always_comb begin
    pick_dma_d  = dma_req && (!cpu_req || !last_dma_q);
    sel_we_d    = pick_dma_d ? dma_we    : cpu_we;
    sel_addr_d  = pick_dma_d ? dma_addr  : cpu_addr;
    sel_wdata_d = pick_dma_d ? dma_wdata : cpu_wdata;
  end

  // FSM with fully registered outputs; pulses default low each cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      last_dma_q    <= 1'b1;
      owner_dma_q   <= 1'b0;
      cpu_gnt_q     <= 1'b0;
      dma_gnt_q     <= 1'b0;
      cpu_rvalid_q  <= 1'b0;
      dma_rvalid_q  <= 1'b0;
      cpu_rdata_q   <= '0;
      dma_rdata_q   <= '0;
      mem_address_q <= '0;
      mem_data_q    <= '0;
      mem_rden_q    <= 1'b0;
      mem_wren_q    <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      cpu_gnt_q    <= 1'b0;
      dma_gnt_q    <= 1'b0;
      cpu_rvalid_q <= 1'b0;
      dma_rvalid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (cpu_req || dma_req) begin
            state_q       <= ACCESS;
            busy_q        <= 1'b1;
            owner_dma_q   <= pick_dma_d;
            last_dma_q    <= pick_dma_d;
            mem_address_q <= sel_addr_d;
            mem_data_q    <= sel_wdata_d;
            mem_wren_q    <= sel_we_d;
            mem_rden_q    <= !sel_we_d;
            cpu_gnt_q     <= !pick_dma_d;
            dma_gnt_q     <= pick_dma_d;
          end
        end
        ACCESS: begin
          // The RAM acts on the enables at this edge; a read then waits one cycle for mem_q.
          mem_rden_q <= 1'b0;
          mem_wren_q <= 1'b0;
          if (mem_rden_q) begin
            state_q <= RDWAIT;
          end else begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end
        RDWAIT: begin
          if (owner_dma_q) begin
            dma_rdata_q  <= mem_q;
            dma_rvalid_q <= 1'b1;
          end else begin
            cpu_rdata_q  <= mem_q;
            cpu_rvalid_q <= 1'b1;
          end
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q    <= IDLE;
          busy_q     <= 1'b0;
          mem_rden_q <= 1'b0;
          mem_wren_q <= 1'b0;
        end
      endcase
    end
  end

  assign cpu_gnt     = cpu_gnt_q;
  assign dma_gnt     = dma_gnt_q;
  assign cpu_rvalid  = cpu_rvalid_q;
  assign dma_rvalid  = dma_rvalid_q;
  assign cpu_rdata   = cpu_rdata_q;
  assign dma_rdata   = dma_rdata_q;
  assign mem_address = mem_address_q;
  assign mem_data    = mem_data_q;
  assign mem_rden    = mem_rden_q;
  assign mem_wren    = mem_wren_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: synchronous RAM model, per-requester read scoreboards, directed scenarios.
// Inputs driven on the falling edge, outputs sampled on the falling edge.
// Every wait on the DUT is bounded; an expired bound is counted as an error.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_req, cpu_we, dma_req, dma_we;
  logic [8:0]  cpu_addr, dma_addr;
  logic [31:0] cpu_wdata, dma_wdata;
  logic        cpu_gnt, dma_gnt, cpu_rvalid, dma_rvalid;
  logic [31:0] cpu_rdata, dma_rdata;
  logic [8:0]  mem_address;
  logic [31:0] mem_data;
  logic        mem_rden, mem_wren;
  logic [31:0] mem_q;
  logic        busy;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] ram     [512];
  logic [31:0] ref_mem [512];
  logic [31:0] cpu_exp_q [$];
  logic [31:0] dma_exp_q [$];
  logic        rst_at_edge = 1'b1;
  logic [31:0] cpu_rdata_prev = '0;
  logic [31:0] dma_rdata_prev = '0;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(9), .DATA_W(32)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .cpu_gnt(cpu_gnt), .dma_gnt(dma_gnt), .cpu_rvalid(cpu_rvalid), .dma_rvalid(dma_rvalid),
    .cpu_rdata(cpu_rdata), .dma_rdata(dma_rdata),
    .mem_address(mem_address), .mem_data(mem_data), .mem_rden(mem_rden), .mem_wren(mem_wren),
    .mem_q(mem_q), .busy(busy)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Synchronous single-port RAM: write at the enable edge, read data one clock later.
  initial begin
    for (int i = 0; i < 512; i++) begin
      ram[i]     = (32'(i) * 32'h01010101) ^ 32'hA5A5A5A5;
      ref_mem[i] = (32'(i) * 32'h01010101) ^ 32'hA5A5A5A5;
    end
    mem_q = '0;
  end

  always @(posedge clk) begin
    if (mem_wren) ram[mem_address] <= mem_data;
    if (mem_rden) mem_q <= ram[mem_address];
    rst_at_edge <= reset;
  end

  // Monitor: scoreboard pops on rvalid, enable exclusivity, rdata hold between completions.
  always @(negedge clk) begin
    chk("excl_rden_wren", {31'b0, mem_rden & mem_wren}, 32'h0);
    if (cpu_rvalid) begin
      if (cpu_exp_q.size() > 0) chk("cpu_rdata", cpu_rdata, cpu_exp_q.pop_front());
      else chk("cpu_rvalid_unexp", {31'b0, cpu_rvalid}, 32'h0);
    end else if (!rst_at_edge) begin
      chk("cpu_rdata_hold", cpu_rdata, cpu_rdata_prev);
    end
    if (dma_rvalid) begin
      if (dma_exp_q.size() > 0) chk("dma_rdata", dma_rdata, dma_exp_q.pop_front());
      else chk("dma_rvalid_unexp", {31'b0, dma_rvalid}, 32'h0);
    end else if (!rst_at_edge) begin
      chk("dma_rdata_hold", dma_rdata, dma_rdata_prev);
    end
    cpu_rdata_prev = cpu_rdata;
    dma_rdata_prev = dma_rdata;
  end

  // Drive one request, record the expectation, wait (bounded) for its gnt, then drop it.
  task automatic do_req(input bit who, input bit we, input logic [8:0] addr,
                        input logic [31:0] data, input int exp_lat, output int lat);
    @(negedge clk);
    if (who) begin
      dma_req = 1'b1; dma_we = we; dma_addr = addr; dma_wdata = data;
    end else begin
      cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = data;
    end
    if (we) ref_mem[addr] = data;
    else if (who) dma_exp_q.push_back(ref_mem[addr]);
    else cpu_exp_q.push_back(ref_mem[addr]);
    lat = 0;
    while (1) begin
      @(negedge clk);
      lat++;
      if ((who && dma_gnt) || (!who && cpu_gnt)) break;
      if (lat > 20) begin
        chk("gnt_timeout", 32'(lat), 32'h0);
        break;
      end
    end
    if (exp_lat > 0) chk("gnt_latency", 32'(lat), 32'(exp_lat));
    if (who) dma_req = 1'b0;
    else cpu_req = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while (busy || cpu_exp_q.size() > 0 || dma_exp_q.size() > 0) begin
      @(negedge clk);
      n++;
      if (n > 50) begin
        chk("drain_timeout", 32'(n), 32'h0);
        cpu_exp_q.delete();
        dma_exp_q.delete();
        break;
      end
    end
  endtask

  // Both requesters issue reads on the same edge; check who is granted first and then second.
  task automatic both_reads(input logic [8:0] ca, input logic [8:0] da, input bit exp_first_dma);
    int n = 0;
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = ca;
    dma_req = 1'b1; dma_we = 1'b0; dma_addr = da;
    cpu_exp_q.push_back(ref_mem[ca]);
    dma_exp_q.push_back(ref_mem[da]);
    while (!(cpu_gnt || dma_gnt) && n <= 20) begin @(negedge clk); n++; end
    chk("pair_first_dma", {31'b0, dma_gnt}, {31'b0, exp_first_dma});
    chk("pair_first_cpu", {31'b0, cpu_gnt}, {31'b0, !exp_first_dma});
    if (dma_gnt) dma_req = 1'b0;
    if (cpu_gnt) cpu_req = 1'b0;
    n = 0;
    do begin @(negedge clk); n++; end while (!(cpu_gnt || dma_gnt) && n <= 20);
    chk("pair_second_dma", {31'b0, dma_gnt}, {31'b0, !exp_first_dma});
    chk("pair_second_cpu", {31'b0, cpu_gnt}, {31'b0, exp_first_dma});
    cpu_req = 1'b0;
    dma_req = 1'b0;
    wait_drain();
  endtask

  initial begin
    int lat;
    int n;
    int last_g;
    int grants;
    reset = 1'b1;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    dma_req = 1'b0; dma_we = 1'b0; dma_addr = '0; dma_wdata = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", {31'b0, busy}, 32'h0);
    chk("rst_gnt", {30'b0, cpu_gnt, dma_gnt}, 32'h0);
    chk("rst_en", {30'b0, mem_rden, mem_wren}, 32'h0);
    chk("rst_addr", {23'b0, mem_address}, 32'h0);
    chk("rst_data", mem_data, 32'h0);
    chk("rst_rdata", cpu_rdata | dma_rdata, 32'h0);
    reset = 1'b0;

    // Simultaneous reads from reset: CPU, then DMA; a second pair alternates back to CPU.
    both_reads(9'h020, 9'h021, 1'b0);
    both_reads(9'h022, 9'h023, 1'b0);

    // CPU write: gnt after one edge, write enable and busy for exactly one cycle.
    do_req(1'b0, 1'b1, 9'h010, 32'hDEADBEEF, 1, lat);
    chk("wr_wren", {31'b0, mem_wren}, 32'h1);
    chk("wr_rden", {31'b0, mem_rden}, 32'h0);
    chk("wr_busy", {31'b0, busy}, 32'h1);
    chk("wr_addr", {23'b0, mem_address}, 32'h010);
    chk("wr_data", mem_data, 32'hDEADBEEF);
    @(negedge clk);
    chk("wr_wren_end", {31'b0, mem_wren}, 32'h0);
    chk("wr_busy_end", {31'b0, busy}, 32'h0);
    chk("idle_addr_hold", {23'b0, mem_address}, 32'h010);

    // CPU read back: rvalid three edges after the request was presented.
    do_req(1'b0, 1'b0, 9'h010, 32'h0, 1, lat);
    n = lat;
    while (!cpu_rvalid && n <= 20) begin @(negedge clk); n++; end
    chk("rd_rvalid_lat", 32'(n), 32'd3);
    chk("rd_dma_rvalid", {31'b0, dma_rvalid}, 32'h0);
    wait_drain();

    // DMA write at the top address, CPU reads it back.
    do_req(1'b1, 1'b1, 9'h1FF, 32'h00000088, 1, lat);
    wait_drain();
    do_req(1'b0, 1'b0, 9'h1FF, 32'h0, 1, lat);
    wait_drain();
    chk("wrap_rdata", cpu_rdata, 32'h00000088);

    // CPU read request held high: one grant every three cycles.
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 9'h055;
    n = 0; last_g = -1; grants = 0;
    while (grants < 4 && n < 40) begin
      @(negedge clk);
      n++;
      if (cpu_gnt) begin
        cpu_exp_q.push_back(ref_mem[9'h055]);
        if (last_g >= 0) chk("held_gnt_gap", 32'(n - last_g), 32'd3);
        last_g = n;
        grants++;
      end
    end
    chk("held_grants", 32'(grants), 32'd4);
    cpu_req = 1'b0;
    wait_drain();

    // Reset in RDWAIT aborts the read and restores the pointer to DMA.
    do_req(1'b0, 1'b0, 9'h066, 32'h0, 1, lat);
    void'(cpu_exp_q.pop_back());
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("rdw_rst_rvalid", {30'b0, cpu_rvalid, dma_rvalid}, 32'h0);
    chk("rdw_rst_busy", {31'b0, busy}, 32'h0);
    chk("rdw_rst_en", {30'b0, mem_rden, mem_wren}, 32'h0);
    chk("rdw_rst_addr", {23'b0, mem_address}, 32'h0);
    chk("rdw_rst_rdata", cpu_rdata | dma_rdata | mem_data, 32'h0);
    @(negedge clk);
    chk("rdw_rst_no_rvalid", {30'b0, cpu_rvalid, dma_rvalid}, 32'h0);
    both_reads(9'h070, 9'h071, 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 9, sets the RAM word-address width.
REQ-002 Parameter DATA_W, default 32, sets the RAM data width.
REQ-003 Port clk, input, 1, is the single clock; all state updates on its rising edge.
REQ-004 Port reset, input, 1, is a synchronous, active-high reset sampled on the rising edge of clk.
REQ-005 Ports cpu_req / dma_req, input, 1, are the access requests from requester 0 (CPU) and requester 1 (DMA).
REQ-006 Ports cpu_we / dma_we, input, 1, select the request type: 1 = write, 0 = read.
REQ-007 Ports cpu_addr / dma_addr, input, ADDR_W, carry the request word address.
REQ-008 Ports cpu_wdata / dma_wdata, input, DATA_W, carry the request write data.
REQ-009 Ports cpu_gnt / dma_gnt, output, 1, each pulse for one cycle when that request is accepted.
REQ-010 Ports cpu_rvalid / dma_rvalid, output, 1, each pulse for one cycle when that requester's rdata is valid.
REQ-011 Ports cpu_rdata / dma_rdata, output, DATA_W, carry read data, held until that requester's next read completes.
REQ-012 Ports mem_address, output, ADDR_W, and mem_data, output, DATA_W, drive the RAM address and write data.
REQ-013 Ports mem_rden / mem_wren, output, 1, drive the RAM read and write enables.
REQ-014 Port mem_q, input, DATA_W, is the RAM read data, valid one clock after the address is captured.
REQ-015 Port busy, output, 1, is high whenever state is not IDLE.

Function
REQ-016 The FSM SHALL have three states: IDLE, ACCESS and RDWAIT.
REQ-017 All outputs SHALL be registered; no output depends combinationally on an input.
REQ-018 Requests SHALL be sampled only in IDLE; a requester holds req, we, addr and wdata stable until it sees its gnt.
REQ-019 Arbitration SHALL be round-robin: if both request, grant the one not granted last; if one requests, grant it.
REQ-020 The last-granted pointer SHALL update on every grant and reset to DMA, so the CPU wins the first tie.
REQ-021 Edge E0 (IDLE, any req=1): enter ACCESS; latch the winner's addr/wdata onto mem_address/mem_data; set mem_wren=we and mem_rden=~we; assert the winner's gnt for exactly this cycle.
REQ-022 Edge E1 (ACCESS): clear mem_rden/mem_wren; a write goes to IDLE, a read goes to RDWAIT.
REQ-023 Edge E2 (RDWAIT): capture mem_q into the granted requester's rdata, pulse its rvalid for one cycle, and go to IDLE.
REQ-024 Latency SHALL be: gnt 1 cycle after sampling; write committed at E1; rvalid 3 cycles after sampling.
REQ-025 A request arriving while busy SHALL wait, unacknowledged, until IDLE.
REQ-026 A req held high after gnt SHALL be treated as a new request at the next IDLE sample.
REQ-027 Back-to-back throughput SHALL be one access per 2 cycles (write) or 3 cycles (read).
REQ-028 The rdata and rvalid of the non-granted requester SHALL never change during another requester's access.
REQ-029 mem_rden and mem_wren SHALL never both be 1, and both SHALL be 0 outside ACCESS.
REQ-030 mem_address and mem_data SHALL hold their last values when idle.

Reset
REQ-031 When reset=1 at a rising edge, state SHALL go to IDLE and the pointer to DMA.
REQ-032 On reset, all gnt, rvalid, mem_rden, mem_wren and busy outputs SHALL be 0, and all rdata, mem_address and mem_data SHALL be 0.
REQ-033 Reset during ACCESS or RDWAIT SHALL abort the access: no rvalid is issued, and a write still in ACCESS is not committed on any later edge.
REQ-034 Reset SHALL take priority over any request sampled on the same edge.

Verification
REQ-035 CPU write: addr 0x010, wdata 0xDEADBEEF, we=1 -> cpu_gnt 1 cycle later, mem_wren=1 for exactly 1 cycle, busy for 1 cycle.
REQ-036 CPU read of 0x010 after REQ-035 -> cpu_rvalid 3 cycles after sampling, cpu_rdata=0xDEADBEEF, dma_rvalid stays 0.
REQ-037 Both request reads at the same edge from reset -> CPU granted first; DMA granted at the next IDLE; a second simultaneous pair -> CPU granted again (alternation holds).
REQ-038 DMA write to 0x1FF (address-width wrap boundary) with data 0x00000088 -> a CPU read of 0x1FF returns 0x00000088.
REQ-039 Reset asserted in RDWAIT -> no rvalid, all outputs 0 next cycle, and the next simultaneous request pair grants the CPU.
REQ-040 CPU req held high continuously with no DMA request -> cpu_gnt every 3 cycles for reads, and mem_rden/mem_wren are never both 1.
